// File: rtl/mfb_frame_checker.sv
// mfb_frame_checker: passive MFB stream monitor with sticky error flags, error pulses and frame/error counters
module mfb_frame_checker #(
    parameter int REGIONS     = 2,
    parameter int REGION_SIZE = 8,
    parameter int BLOCK_SIZE  = 8,
    parameter int ITEM_WIDTH  = 8,
    parameter int MIN_LEN     = 60,
    parameter int MAX_LEN     = 1526,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                                                CLK,
    input  logic                                                RESET_N,
    input  logic [REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0] RX_DATA,
    input  logic [REGIONS-1:0]                                  RX_SOF,
    input  logic [REGIONS-1:0]                                  RX_EOF,
    input  logic [REGIONS*$clog2(REGION_SIZE)-1:0]              RX_SOF_POS,
    input  logic [REGIONS*$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]   RX_EOF_POS,
    input  logic                                                RX_SRC_RDY,
    input  logic                                                RX_DST_RDY,
    input  logic                                                CLEAR,
    output logic [4:0]                                          ERR_VEC,
    output logic [4:0]                                          ERR_PULSE,
    output logic [CNT_WIDTH-1:0]                                FRAME_CNT,
    output logic [CNT_WIDTH-1:0]                                ERR_CNT
);
    localparam int SW = $clog2(REGION_SIZE);
    localparam int EW = $clog2(REGION_SIZE*BLOCK_SIZE);
    localparam int RI = REGION_SIZE*BLOCK_SIZE;
    localparam int LW = $clog2(MAX_LEN+2+RI);
    localparam logic [LW-1:0] L_RI  = LW'(RI);
    localparam logic [LW-1:0] L_BS  = LW'(BLOCK_SIZE);
    localparam logic [LW-1:0] L_SAT = LW'(MAX_LEN+1);
    localparam logic [LW-1:0] L_MIN = LW'(MIN_LEN);
    localparam logic [LW-1:0] L_MAX = LW'(MAX_LEN);
    localparam logic [LW-1:0] L_ONE = LW'(1);
    localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

    logic                 in_frame, in_c, done, hold_pend, hold_err;
    logic [LW-1:0]        len, len_c, flen, si, ei;
    logic [4:0]           err;
    logic [CNT_WIDTH-1:0] nev, nfr;
    logic [REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0] h_data;
    logic [REGIONS-1:0]   h_sof, h_eof;
    logic [REGIONS*SW-1:0] h_sp;
    logic [REGIONS*EW-1:0] h_ep;

    // length never grows past MAX_LEN+1 so oversize stays detectable without a wide counter
    function automatic logic [LW-1:0] sat(input logic [LW-1:0] a);
        return a > L_SAT ? L_SAT : a;
    endfunction

    // walk regions in order, carrying frame state, and collect this cycle's error events
    always_comb begin
        in_c = in_frame;
        len_c = len;
        err = '0;
        nev = '0;
        nfr = '0;
        done = 1'b0;
        flen = '0;
        si = '0;
        ei = '0;
        hold_err = hold_pend && (!RX_SRC_RDY || RX_DATA != h_data || RX_SOF != h_sof ||
                   RX_EOF != h_eof || RX_SOF_POS != h_sp || RX_EOF_POS != h_ep);
        if (hold_err) begin
            err[2] = 1'b1;
            nev = nev + C_ONE;
        end
        if (RX_SRC_RDY && RX_DST_RDY) begin
            for (int r = 0; r < REGIONS; r++) begin
                done = 1'b0;
                flen = '0;
                si = LW'(RX_SOF_POS[r*SW +: SW]) * L_BS;
                ei = LW'(RX_EOF_POS[r*EW +: EW]);
                if (RX_SOF[r] && RX_EOF[r] && in_c && ei < si) begin
                    done = 1'b1;
                    flen = sat(len_c + ei + L_ONE);
                    len_c = sat(L_RI - si);
                end else if (RX_SOF[r] && RX_EOF[r] && in_c) begin
                    err[0] = 1'b1;
                    nev = nev + C_ONE;
                    done = 1'b1;
                    flen = sat(ei - si + L_ONE);
                    in_c = 1'b0;
                    len_c = '0;
                end else if (RX_SOF[r] && RX_EOF[r] && ei >= si) begin
                    done = 1'b1;
                    flen = sat(ei - si + L_ONE);
                    len_c = '0;
                end else if (RX_SOF[r] && RX_EOF[r]) begin
                    err[1] = 1'b1;
                    nev = nev + C_ONE;
                    in_c = 1'b1;
                    len_c = sat(L_RI - si);
                end else if (RX_SOF[r]) begin
                    if (in_c) begin
                        err[0] = 1'b1;
                        nev = nev + C_ONE;
                    end
                    in_c = 1'b1;
                    len_c = sat(L_RI - si);
                end else if (RX_EOF[r] && in_c) begin
                    done = 1'b1;
                    flen = sat(len_c + ei + L_ONE);
                    in_c = 1'b0;
                    len_c = '0;
                end else if (RX_EOF[r]) begin
                    err[1] = 1'b1;
                    nev = nev + C_ONE;
                end else if (in_c) begin
                    len_c = sat(len_c + L_RI);
                end
                if (done) begin
                    nfr = nfr + C_ONE;
                    if (flen < L_MIN) begin
                        err[3] = 1'b1;
                        nev = nev + C_ONE;
                    end
                    if (flen > L_MAX) begin
                        err[4] = 1'b1;
                        nev = nev + C_ONE;
                    end
                end
            end
        end
    end

    // frame state, hold snapshot and registered statistics; CLEAR leaves frame and hold tracking alone
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            in_frame <= 1'b0;
            len <= '0;
            hold_pend <= 1'b0;
            h_data <= '0;
            h_sof <= '0;
            h_eof <= '0;
            h_sp <= '0;
            h_ep <= '0;
            ERR_PULSE <= '0;
            ERR_VEC <= '0;
            FRAME_CNT <= '0;
            ERR_CNT <= '0;
        end else begin
            in_frame <= in_c;
            len <= len_c;
            hold_pend <= RX_SRC_RDY && !RX_DST_RDY;
            h_data <= RX_DATA;
            h_sof <= RX_SOF;
            h_eof <= RX_EOF;
            h_sp <= RX_SOF_POS;
            h_ep <= RX_EOF_POS;
            ERR_PULSE <= err;
            ERR_VEC <= CLEAR ? '0 : ERR_VEC | err;
            FRAME_CNT <= CLEAR ? '0 : FRAME_CNT + nfr;
            ERR_CNT <= CLEAR ? '0 : ERR_CNT + nev;
        end
    end
endmodule
